// File: rtl/tt_alu_sequencer.sv
// tt_alu_sequencer: start/operand/exec sequencer driving an 8-bit ADD/XOR/AND/SUB unit with abort and freeze
module tt_alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] OPA  = 3'd1;
  localparam logic [2:0] OPB  = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  logic [2:0] state, nxt;
  logic [7:0] a, b, result;
  logic [1:0] op;
  logic       carry, busy, done, start, valid, abort_hit, unused;
  logic [8:0] alu;
  assign start = uio_in[0];
  assign valid = uio_in[1];
  assign busy = state == OPA || state == OPB || state == EXEC;
  assign done = state == DONE;
  assign abort_hit = uio_in[4] && busy;
  assign unused = &{1'b0, uio_in[7:5]};
  assign uo_out = result;
  assign uio_out = {carry, done, busy, 5'b0};
  assign uio_oe = 8'hE0;
  // bit 8 of the 9-bit difference is exactly the borrow (A < B)
  always_comb begin
    alu = op == 2'b00 ? {1'b0, a} + {1'b0, b} :
          op == 2'b01 ? {1'b0, a ^ b} :
          op == 2'b10 ? {1'b0, a & b} :
                        {1'b0, a} - {1'b0, b};
    nxt = abort_hit      ? IDLE :
          state == IDLE  ? (start ? OPA : IDLE) :
          state == OPA   ? (valid ? OPB : OPA) :
          state == OPB   ? (valid ? EXEC : OPB) :
          state == EXEC  ? DONE :
          state == DONE  ? (start ? DONE : IDLE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      op     <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else if (ena) begin
      state <= nxt;
      if (state == IDLE && start) op <= uio_in[3:2];
      if (!abort_hit && state == OPA && valid) a <= ui_in;
      if (!abort_hit && state == OPB && valid) b <= ui_in;
      if (!abort_hit && state == EXEC) {carry, result} <= alu;
    end
  end
endmodule
